// File: rtl/guvm_instr_feeder.sv
// guvm_instr_feeder: OBI-style instruction-fetch responder fed from a bench-filled FIFO.
//  clk_i/rst_ni       clock, async active-low reset
//  instr_req_o/addr_o core fetch request and address (inputs here)
//  instr_gnt_i        combinational grant; instr_rvalid_i/rdata_i registered response
//  stall_i/flush_i    grant suppression, FIFO clear
//  push_*             bench FIFO write port; level_o occupancy
//  trace_*            granted fetch address, one cycle later
//  fetch_cnt_o/nop_cnt_o saturating fetch and NOP-answer counters
module guvm_instr_feeder #(
  parameter int          DEPTH    = 8,
  parameter int          DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INSN = 32'h00000013,
  parameter int          CNT_W    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     instr_req_o,
  input  logic [31:0]              instr_addr_o,
  output logic                     instr_gnt_i,
  output logic                     instr_rvalid_i,
  output logic [DATA_W-1:0]        instr_rdata_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     push_valid_i,
  input  logic [DATA_W-1:0]        push_data_i,
  output logic                     push_ready_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     trace_valid_o,
  output logic [31:0]              trace_addr_o,
  output logic [CNT_W-1:0]         fetch_cnt_o,
  output logic [CNT_W-1:0]         nop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic empty, nop, push, pop;
  assign instr_gnt_i  = instr_req_o & ~stall_i & rst_ni;
  assign push_ready_o = level_o != LW'(DEPTH);
  assign empty        = level_o == '0;
  // a flush discards the queue, so a grant in that cycle sees it as empty
  assign nop          = empty | flush_i;
  assign pop          = instr_gnt_i & ~nop;
  assign push         = push_valid_i & push_ready_o & ~flush_i;
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_data_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      level_o        <= '0;
      instr_rvalid_i <= 1'b0;
      instr_rdata_i  <= '0;
      trace_valid_o  <= 1'b0;
      trace_addr_o   <= '0;
      fetch_cnt_o    <= '0;
      nop_cnt_o      <= '0;
    end else begin
      if (flush_i) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        level_o <= '0;
      end else begin
        rd_ptr  <= rd_ptr + AW'(pop);
        wr_ptr  <= wr_ptr + AW'(push);
        level_o <= level_o + LW'(push) - LW'(pop);
      end
      instr_rvalid_i <= instr_gnt_i;
      trace_valid_o  <= instr_gnt_i;
      if (instr_gnt_i) begin
        instr_rdata_i <= nop ? NOP_INSN : mem[rd_ptr];
        trace_addr_o  <= instr_addr_o;
        if (fetch_cnt_o != '1) fetch_cnt_o <= fetch_cnt_o + 1'b1;
        if (nop && nop_cnt_o != '1) nop_cnt_o <= nop_cnt_o + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_guvm_instr_feeder.sv
// tb_guvm_instr_feeder: directed self-checking bench for guvm_instr_feeder.
module tb_guvm_instr_feeder;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0, stall = 1'b0, flush = 1'b0, pv = 1'b0;
  logic [31:0] addr = '0, pd = '0;
  logic gnt, rvalid, pr, tv;
  logic [31:0] rdata, ta;
  logic [3:0] level;
  logic [15:0] fc, nc;
  int tests = 0, fails = 0;

  guvm_instr_feeder dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_o(req), .instr_addr_o(addr),
    .instr_gnt_i(gnt), .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
    .stall_i(stall), .flush_i(flush), .push_valid_i(pv), .push_data_i(pd),
    .push_ready_o(pr), .level_o(level), .trace_valid_o(tv), .trace_addr_o(ta),
    .fetch_cnt_o(fc), .nop_cnt_o(nc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 1'b0; stall = 1'b0; flush = 1'b0; pv = 1'b0; pd = '0; addr = '0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_word(input logic [31:0] w);
    pv = 1'b1; pd = w;
    step();
    pv = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    tests++;
    if ({rvalid, rdata, tv, ta, fc, nc, level, gnt} !== '0) begin
      fails++; $display("FAIL reset_state rv=%b rd=%h tv=%b ta=%h fc=%0d nc=%0d lvl=%0d gnt=%b", rvalid, rdata, tv, ta, fc, nc, level, gnt);
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (pr !== 1'b1 || rvalid !== 1'b0) begin
      fails++; $display("FAIL reset_release pr=%b rv=%b want 1 0", pr, rvalid);
    end
    push_word(32'hAAAA5555);
    req = 1'b1; addr = 32'h40;
    step();
    tests++;
    if (rvalid !== 1'b1 || rdata !== 32'hAAAA5555 || fc !== 16'd1) begin
      fails++; $display("FAIL reset_pre_resp rv=%b rd=%h fc=%0d want 1 aaaa5555 1", rvalid, rdata, fc);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({rvalid, rdata, tv, ta, fc, nc, level, gnt} !== '0) begin
      fails++; $display("FAIL reset_async rv=%b rd=%h tv=%b ta=%h fc=%0d nc=%0d lvl=%0d gnt=%b want all 0", rvalid, rdata, tv, ta, fc, nc, level, gnt);
    end
    req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    tests++;
    if (rvalid !== 1'b0 || level !== 4'd0) begin
      fails++; $display("FAIL reset_no_spurious rv=%b lvl=%0d want 0 0", rvalid, level);
    end
    req = 1'b1;
    #1;
    tests++;
    if (gnt !== 1'b1) begin
      fails++; $display("FAIL reset_gnt got %b want 1", gnt);
    end
    step();
    req = 1'b0;
    tests++;
    if (rvalid !== 1'b1 || rdata !== NOP || fc !== 16'd1 || nc !== 16'd1) begin
      fails++; $display("FAIL reset_after_fetch rv=%b rd=%h fc=%0d nc=%0d want 1 00000013 1 1", rvalid, rdata, fc, nc);
    end
  endtask

  task automatic test_in_order();
    logic [31:0] w [3];
    w = '{32'h00500093, 32'h00308113, 32'h002081B3};
    do_reset();
    for (int i = 0; i < 3; i++) push_word(w[i]);
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 32'h80 + 32'(4 * i);
      step();
      tests++;
      if (rvalid !== 1'b1 || rdata !== w[i] || tv !== 1'b1 || ta !== 32'h80 + 32'(4 * i)) begin
        fails++; $display("FAIL in_order_%0d rv=%b rd=%h tv=%b ta=%h want 1 %h 1 %h", i, rvalid, rdata, tv, ta, w[i], 32'h80 + 32'(4 * i));
      end
    end
    req = 1'b0;
    tests++;
    if (fc !== 16'd3 || nc !== 16'd0 || level !== 4'd0) begin
      fails++; $display("FAIL in_order_counts fc=%0d nc=%0d lvl=%0d want 3 0 0", fc, nc, level);
    end
    step();
    tests++;
    if (rvalid !== 1'b0 || tv !== 1'b0 || rdata !== w[2]) begin
      fails++; $display("FAIL in_order_hold rv=%b tv=%b rd=%h want 0 0 %h", rvalid, tv, rdata, w[2]);
    end
  endtask

  task automatic test_empty();
    do_reset();
    req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'h100 + 32'(4 * i);
      step();
      tests++;
      if (rvalid !== 1'b1 || rdata !== NOP) begin
        fails++; $display("FAIL empty_%0d rv=%b rd=%h want 1 %h", i, rvalid, rdata, NOP);
      end
    end
    req = 1'b0;
    tests++;
    if (nc !== 16'd4 || fc !== 16'd4) begin
      fails++; $display("FAIL empty_counts nc=%0d fc=%0d want 4 4", nc, fc);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (pr !== (i < 8)) begin
        fails++; $display("FAIL full_ready_%0d got %b want %b", i, pr, i < 8);
      end
      push_word(32'(i + 1));
    end
    tests++;
    if (level !== 4'd8 || pr !== 1'b0) begin
      fails++; $display("FAIL full_level lvl=%0d pr=%b want 8 0", level, pr);
    end
    req = 1'b1; addr = 32'h200; pv = 1'b1; pd = 32'hDEAD;
    step();
    req = 1'b0; pv = 1'b0;
    tests++;
    if (rdata !== 32'd1 || level !== 4'd7 || pr !== 1'b1) begin
      fails++; $display("FAIL full_pop rd=%h lvl=%0d pr=%b want 1 7 1", rdata, level, pr);
    end
    req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (rdata !== (i < 7 ? 32'(i + 2) : NOP)) begin
        fails++; $display("FAIL full_drain_%0d rd=%h want %h", i, rdata, i < 7 ? 32'(i + 2) : NOP);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    push_word(32'h12345678);
    req = 1'b1; stall = 1'b1; addr = 32'h44;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (gnt !== 1'b0) begin
        fails++; $display("FAIL stall_gnt_%0d got %b want 0", i, gnt);
      end
      step();
      tests++;
      if (rvalid !== 1'b0) begin
        fails++; $display("FAIL stall_rvalid_%0d got %b want 0", i, rvalid);
      end
    end
    tests++;
    if (fc !== 16'd0 || nc !== 16'd0 || level !== 4'd1) begin
      fails++; $display("FAIL stall_counts fc=%0d nc=%0d lvl=%0d want 0 0 1", fc, nc, level);
    end
    stall = 1'b0;
    #1;
    tests++;
    if (gnt !== 1'b1) begin
      fails++; $display("FAIL stall_release_gnt got %b want 1", gnt);
    end
    step();
    req = 1'b0;
    tests++;
    if (rvalid !== 1'b1 || rdata !== 32'h12345678 || ta !== 32'h44) begin
      fails++; $display("FAIL stall_release_resp rv=%b rd=%h ta=%h want 1 12345678 44", rvalid, rdata, ta);
    end
  endtask

  task automatic test_flush();
    do_reset();
    push_word(32'h11); push_word(32'h22); push_word(32'h33);
    flush = 1'b1; pv = 1'b1; pd = 32'hBEEF; req = 1'b1; addr = 32'h300;
    #1;
    tests++;
    if (gnt !== 1'b1) begin
      fails++; $display("FAIL flush_gnt got %b want 1", gnt);
    end
    step();
    flush = 1'b0; pv = 1'b0;
    tests++;
    if (rvalid !== 1'b1 || rdata !== NOP || level !== 4'd0 || nc !== 16'd1 || fc !== 16'd1) begin
      fails++; $display("FAIL flush_resp rv=%b rd=%h lvl=%0d nc=%0d fc=%0d want 1 %h 0 1 1", rvalid, rdata, level, nc, fc, NOP);
    end
    step();
    req = 1'b0;
    tests++;
    if (rdata !== NOP || nc !== 16'd2) begin
      fails++; $display("FAIL flush_push_dropped rd=%h nc=%0d want %h 2", rdata, nc, NOP);
    end
  endtask

  task automatic test_no_bypass();
    do_reset();
    pv = 1'b1; pd = 32'hC0DE; req = 1'b1; addr = 32'h400;
    step();
    pv = 1'b0;
    tests++;
    if (rdata !== NOP || level !== 4'd1) begin
      fails++; $display("FAIL no_bypass rd=%h lvl=%0d want %h 1", rdata, level, NOP);
    end
    step();
    req = 1'b0;
    tests++;
    if (rdata !== 32'hC0DE || level !== 4'd0) begin
      fails++; $display("FAIL no_bypass_retained rd=%h lvl=%0d want c0de 0", rdata, level);
    end
  endtask

  task automatic test_back_to_back_push_pop();
    do_reset();
    push_word(32'hA1);
    pv = 1'b1; pd = 32'hA2; req = 1'b1;
    step();
    pv = 1'b0; req = 1'b0;
    tests++;
    if (rdata !== 32'hA1 || level !== 4'd1) begin
      fails++; $display("FAIL push_pop_same rd=%h lvl=%0d want a1 1", rdata, level);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_empty();
    test_full();
    test_stall();
    test_flush();
    test_no_bypass();
    test_back_to_back_push_pop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
